serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a subtraction; sampled on the rising edge of clk.
REQ-005 A  input  WIDTH  minuend; sampled only on the edge where start is accepted.
REQ-006 B  input  WIDTH  subtrahend; sampled only on the edge where start is accepted.
REQ-007 busy  output  1  high while bits are being processed (state SHIFT).
REQ-008 done  output  1  one-cycle pulse; Diff and Borrow are valid.
REQ-009 Diff  output  WIDTH  result A - B, modulo 2^WIDTH.
REQ-010 Borrow  output  1  final borrow-out; 1 exactly when A < B (unsigned).

Function
REQ-011 The block SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 at an edge SHALL be accepted:
- A and B loaded into shift registers;
- internal borrow flop cleared to 0;
- bit counter cleared to 0;
- next state SHIFT.
REQ-013 start SHALL be ignored in SHIFT and DONE; operands and results are not disturbed.
REQ-014 Each SHIFT edge SHALL process one bit, LSB first, as a full subtractor.
- difference bit d = a ^ b ^ bin
- borrow out = (~a & b) | (~(a ^ b) & bin)
REQ-015 On each SHIFT edge:
- d shifts into the result register from the MSB side;
- operand registers shift right;
- borrow flop takes the borrow out;
- counter increments.
REQ-016 On the SHIFT edge that processes bit WIDTH-1, the next state SHALL be DONE.
REQ-017 In DONE, done=1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-018 Latency: start accepted at edge k -> done high during the cycle following edge k+WIDTH.
REQ-019 Diff and Borrow SHALL be driven from registers and hold their value until the next accepted start.
REQ-020 Diff and Borrow are undefined between an accepted start and the following done.
REQ-021 Minimum spacing between accepted starts SHALL be WIDTH+2 edges (start held high back-to-back).
REQ-022 WIDTH=1 SHALL work: one SHIFT cycle, then DONE.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk:
- force state to IDLE;
- set busy=0, done=0, Diff=0, Borrow=0;
- clear counter, operand registers and borrow flop.
REQ-024 Reset during SHIFT or DONE SHALL abort the operation; no done pulse follows.
REQ-025 The first edge after rst_n rises SHALL be able to accept start.

Configuration
REQ-026 Macro SERIAL_SUB_ZERO_FLAG_EN defined:
- adds output Zero (1 bit), registered;
- Zero=1 when Diff==0, valid with done, held with Diff;
- Zero resets to 0.
REQ-027 Macro SERIAL_SUB_ZERO_FLAG_EN undefined: port Zero is absent; all other behaviour is identical.

Verification
REQ-028 WIDTH=8, A=0x5A, B=0x3C, start pulse -> done 8 cycles later; Diff=0x1E, Borrow=0.
REQ-029 A=0x00, B=0x01 -> Diff=0xFF, Borrow=1.
REQ-030 A=0x80, B=0x80 with SERIAL_SUB_ZERO_FLAG_EN defined -> Diff=0x00, Borrow=0, Zero=1.
REQ-031 Start with A=0x10, B=0x01, then start with A=0xFF, B=0x00 at SHIFT cycle 3 -> Diff=0x0F; the second start is ignored.
REQ-032 rst_n low at SHIFT cycle 4 -> busy, done, Diff, Borrow all 0 at once; no done pulse; a following start with A=0x03, B=0x05 -> Diff=0xFE, Borrow=1.
REQ-033 start held high continuously -> done pulses every 10 edges; results match each sampled A, B.

Source files
------------

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/operand/result bundle for serial_sub; Zero present only with SERIAL_SUB_ZERO_FLAG_EN
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             Zero;

    modport master (output start, A, B, input busy, done, Diff, Borrow, Zero);
    modport slave  (input start, A, B, output busy, done, Diff, Borrow, Zero);
`else
    modport master (output start, A, B, input busy, done, Diff, Borrow);
    modport slave  (input start, A, B, output busy, done, Diff, Borrow);
`endif
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - LSB-first bit-serial subtractor A - B; SERIAL_SUB_ZERO_FLAG_EN adds a registered Zero flag
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] d_msb;
    logic [WIDTH-1:0] diff_shift;

    // Next-state and datapath: load on accepted start, one full-subtractor step per SHIFT cycle
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        bit_d       = a_q[0] ^ b_q[0] ^ borrow_q;
        bit_bout    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        d_msb       = '0;
        d_msb[WIDTH-1] = bit_d;
        diff_shift  = (diff_q >> 1) | d_msb;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                diff_d   = diff_shift;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = bit_bout;
                cnt_d    = cnt_q + CNT_W'(1);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                // Final value is correct after the last bit; tracks Diff like every other result bit
                zero_d   = (diff_shift == '0);
`endif
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign bus.busy   = (state_q == SHIFT);
    assign bus.done   = (state_q == DONE);
    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    assign bus.Zero   = zero_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed scoreboard bench for serial_sub (WIDTH=8)
module tb_serial_sub;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(W)) sif ();

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       m;
        logic [W:0] r;
        r        = {1'b0, a} - {1'b0, b};
        m.diff   = r[W-1:0];
        m.borrow = (a < b);
        m.zero   = (r[W-1:0] == '0);
        return m;
    endfunction

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        sb.push_back(model(a, b));
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, ".pending"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".diff"}, sif.Diff, e.diff);
            check({tag, ".borrow"}, sif.Borrow, e.borrow);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            check({tag, ".zero"}, sif.Zero, e.zero);
`endif
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (sif.done !== 1'b1 && cyc < 40);
    endtask

    task automatic scramble();
        sif.A = W'($urandom);
        sif.B = W'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc;
        @(posedge clk);
        #1;
        sif.A = a;
        sif.B = b;
        sif.start = 1'b1;
        push(a, b);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        scramble();
        wait_done(cyc);
        check({tag, ".latency"}, cyc, W + 1);
        pop_check(tag);
        @(negedge clk);
        check({tag, ".done_pulse"}, sif.done, 1'b0);
        check({tag, ".hold"}, sif.Diff, model(a, b).diff);
    endtask

    logic [W-1:0] opa [6];
    logic [W-1:0] opb [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_done;

        sif.start = 1'b0;
        sif.A = '0;
        sif.B = '0;

        // Reset state
        #1;
        check("rst.busy", sif.busy, 1'b0);
        check("rst.done", sif.done, 1'b0);
        check("rst.diff", sif.Diff, 8'h00);
        check("rst.borrow", sif.Borrow, 1'b0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        check("rst.zero", sif.Zero, 1'b0);
`endif

        // Release reset and start on the very first edge: 0x5A - 0x3C
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sif.A = 8'h5A;
        sif.B = 8'h3C;
        sif.start = 1'b1;
        push(8'h5A, 8'h3C);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        check("first.busy", sif.busy, 1'b1);
        scramble();
        wait_done(cyc);
        check("first.latency", cyc, W + 1);
        pop_check("first");
        check("first.diff_const", sif.Diff, 8'h1E);

        run_op("0m1", 8'h00, 8'h01);
        check("0m1.borrow_const", sif.Borrow, 1'b1);
        run_op("eq80", 8'h80, 8'h80);

        // Second start during SHIFT cycle 3 must be ignored
        @(posedge clk);
        #1;
        sif.A = 8'h10;
        sif.B = 8'h01;
        sif.start = 1'b1;
        push(8'h10, 8'h01);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sif.A = 8'hFF;
        sif.B = 8'h00;
        sif.start = 1'b1;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        wait_done(cyc);
        pop_check("ignore");
        check("ignore.diff_const", sif.Diff, 8'h0F);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sif.done === 1'b1) n_done++;
        end
        check("ignore.no_extra_done", n_done, 0);
        check("ignore.hold", sif.Diff, 8'h0F);

        // Reset during SHIFT cycle 4 aborts the operation
        @(posedge clk);
        #1;
        sif.A = 8'h77;
        sif.B = 8'h11;
        sif.start = 1'b1;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("abort.busy_before", sif.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort.busy", sif.busy, 1'b0);
        check("abort.done", sif.done, 1'b0);
        check("abort.diff", sif.Diff, 8'h00);
        check("abort.borrow", sif.Borrow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sif.done === 1'b1) n_done++;
        end
        check("abort.no_done", n_done, 0);
        run_op("after_abort", 8'h03, 8'h05);
        check("after_abort.diff_const", sif.Diff, 8'hFE);

        // start held high: one result every W+2 edges
        opa[0] = 8'h5A; opb[0] = 8'h3C;
        opa[1] = 8'hFF; opb[1] = 8'hFF;
        opa[2] = 8'h00; opb[2] = 8'hFF;
        opa[3] = 8'hFF; opb[3] = 8'h00;
        opa[4] = W'($urandom); opb[4] = W'($urandom);
        opa[5] = W'($urandom); opb[5] = W'($urandom);
        @(posedge clk);
        #1;
        sif.A = opa[0];
        sif.B = opb[0];
        sif.start = 1'b1;
        push(opa[0], opb[0]);
        @(posedge clk);
        #1;
        scramble();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                wait_done(cyc);
                check("b2b.latency", cyc, W + 1);
            end else begin
                cyc = 0;
                do begin
                    @(negedge clk);
                    cyc++;
                    if (cyc == 2) scramble();
                end while (sif.done !== 1'b1 && cyc < 40);
                check($sformatf("b2b%0d.period", i), cyc, W + 2);
            end
            pop_check($sformatf("b2b%0d", i));
            if (i < 5) begin
                sif.A = opa[i + 1];
                sif.B = opb[i + 1];
                push(opa[i + 1], opb[i + 1]);
            end else begin
                sif.start = 1'b0;
            end
        end
        @(negedge clk);

        // A few random operands
        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
